// File: rtl/write_back_pipe.sv
// rtl/write_back_pipe.sv - registered MEM/WB write-back stage with variable-latency load wait
// Optional feature macro: WB_PERF_CNT_EN adds retire_cnt / stall_cnt saturating counters.
module write_back_pipe #(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_memtoreg,
  input  logic                          in_regwrite,
  input  logic [ADDR_W-1:0]             in_rd,
  input  logic [WIDTH-1:0]              in_alu_result,
  input  logic [1:0]                    in_size,
  input  logic                          in_signed,
  input  logic [$clog2(WIDTH/8)-1:0]    in_byte_off,
  input  logic                          mem_rvalid,
  input  logic [WIDTH-1:0]              mem_rdata,
  output logic                          wb_en,
  output logic [ADDR_W-1:0]             wb_addr,
  output logic [WIDTH-1:0]              wb_data,
  output logic                          stall
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]                   retire_cnt,
  output logic [31:0]                   stall_cnt
`endif
);

  localparam int OFF_W = $clog2(WIDTH/8);

  typedef enum logic {IDLE, WAIT_MEM} state_t;
  state_t state, state_n;

  logic              accept;
  logic [ADDR_W-1:0] p_rd;
  logic              p_regwrite;
  logic [1:0]        p_size;
  logic              p_signed;
  logic [OFF_W-1:0]  p_off;

  logic [1:0]        x_size;
  logic              x_signed;
  logic [OFF_W-1:0]  x_off;
  logic [WIDTH-1:0]  shifted, mask, topbit, ext;
  int                kbits;

  logic              wr_go, wr_rw, wb_en_n;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (accept && in_memtoreg && !mem_rvalid) state_n = WAIT_MEM;
      WAIT_MEM: if (mem_rvalid) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    stall    = (state == WAIT_MEM);
  end

  // While waiting, the extractor uses the captured load fields rather than the held inputs.
  always_comb begin
    x_size   = (state == WAIT_MEM) ? p_size   : in_size;
    x_signed = (state == WAIT_MEM) ? p_signed : in_signed;
    x_off    = (state == WAIT_MEM) ? p_off    : in_byte_off;
    shifted  = mem_rdata >> {x_off, 3'b000};
    case (x_size)
      2'd0:    kbits = 8;
      2'd1:    kbits = 16;
      2'd2:    kbits = 32;
      default: kbits = 64;
    endcase
    if (kbits >= WIDTH) begin
      mask   = '1;
      topbit = WIDTH'(1) << (WIDTH - 1);
    end else begin
      mask   = (WIDTH'(1) << kbits) - WIDTH'(1);
      topbit = WIDTH'(1) << (kbits - 1);
    end
    ext = shifted & mask;
    if (x_signed && (|(shifted & topbit))) ext = ext | ~mask;
  end

  always_comb begin
    wr_go   = 1'b0;
    wr_rw   = in_regwrite;
    wr_addr = in_rd;
    wr_data = in_alu_result;
    if (state == WAIT_MEM) begin
      if (mem_rvalid) begin
        wr_go   = 1'b1;
        wr_rw   = p_regwrite;
        wr_addr = p_rd;
        wr_data = ext;
      end
    end else if (accept) begin
      if (!in_memtoreg) begin
        wr_go = 1'b1;
      end else if (mem_rvalid) begin
        wr_go   = 1'b1;
        wr_data = ext;
      end
    end
    wb_en_n = wr_go & wr_rw & (wr_addr != ADDR_W'(ZERO_REG));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_en   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_en <= wb_en_n;
      if (wr_go) begin
        wb_addr <= wr_addr;
        wb_data <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_rd       <= '0;
      p_regwrite <= 1'b0;
      p_size     <= '0;
      p_signed   <= 1'b0;
      p_off      <= '0;
    end else if (state == IDLE && accept && in_memtoreg && !mem_rvalid) begin
      p_rd       <= in_rd;
      p_regwrite <= in_regwrite;
      p_size     <= in_size;
      p_signed   <= in_signed;
      p_off      <= in_byte_off;
    end
  end

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (wb_en_n && retire_cnt != 32'hFFFF_FFFF) retire_cnt <= retire_cnt + 32'd1;
      if (stall && stall_cnt != 32'hFFFF_FFFF)    stall_cnt  <= stall_cnt + 32'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_write_back_pipe.sv
// tb/tb_write_back_pipe.sv - directed bench with reference model for write_back_pipe
module tb_write_back_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic        in_memtoreg = 1'b0, in_regwrite = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [63:0] in_alu_result = '0;
  logic [1:0]  in_size = '0;
  logic        in_signed = 1'b0;
  logic [2:0]  in_byte_off = '0;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        wb_en, stall;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
`ifdef WB_PERF_CNT_EN
  logic [31:0] retire_cnt, stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  bit checking = 0;

  always #5 clk = ~clk;

  write_back_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_memtoreg(in_memtoreg), .in_regwrite(in_regwrite), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_size(in_size), .in_signed(in_signed),
    .in_byte_off(in_byte_off), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall)
`ifdef WB_PERF_CNT_EN
    , .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Sub-word load as arithmetic: take the field modulo 2^bits, then wrap negative values.
  function automatic logic [63:0] m_ext(input logic [63:0] d, input int size, input bit sgn, input int off);
    logic [63:0] v;
    int bits;
    v = d >> (off * 8);
    bits = 8 << size;
    if (bits < 64) begin
      v = v % (64'd1 << bits);
      if (sgn && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    end
    return v;
  endfunction

  bit          m_pend = 0;
  int          m_rd = 0, m_size = 0, m_off = 0;
  bit          m_rw = 0, m_sgn = 0;
  bit          exp_en = 0;
  logic [4:0]  exp_addr = '0;
  logic [63:0] exp_data = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend = 0; exp_en = 0; exp_addr = '0; exp_data = '0;
    end else begin
      exp_en = 0;
      if (m_pend) begin
        if (mem_rvalid) begin
          exp_addr = 5'(m_rd);
          exp_data = m_ext(mem_rdata, m_size, m_sgn, m_off);
          exp_en   = m_rw && m_rd != 31;
          m_pend   = 0;
        end
      end else if (in_valid) begin
        if (!in_memtoreg || mem_rvalid) begin
          exp_addr = in_rd;
          exp_data = in_memtoreg ? m_ext(mem_rdata, int'(in_size), in_signed, int'(in_byte_off)) : in_alu_result;
          exp_en   = in_regwrite && in_rd != 5'd31;
        end else begin
          m_pend = 1; m_rd = int'(in_rd); m_rw = in_regwrite;
          m_size = int'(in_size); m_sgn = in_signed; m_off = int'(in_byte_off);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("wb_en",    {63'd0, wb_en},    {63'd0, exp_en});
      check("wb_addr",  {59'd0, wb_addr},  {59'd0, exp_addr});
      check("wb_data",  wb_data,           exp_data);
      check("in_ready", {63'd0, in_ready}, {63'd0, !m_pend});
      check("stall",    {63'd0, stall},    {63'd0, m_pend});
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic rw, input logic [63:0] alu);
    in_valid = 1; in_memtoreg = 0; in_regwrite = rw; in_rd = rd; in_alu_result = alu; mem_rvalid = 0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [1:0] sz, input logic sg, input logic [2:0] off,
                          input logic rv, input logic [63:0] rdata);
    in_valid = 1; in_memtoreg = 1; in_regwrite = 1; in_rd = rd; in_size = sz; in_signed = sg;
    in_byte_off = off; mem_rvalid = rv; mem_rdata = rdata;
  endtask

  task automatic idle_in();
    in_valid = 0; mem_rvalid = 0;
  endtask

  initial begin
    #1;
    check("reset wb_en",    {63'd0, wb_en},    64'd0);
    check("reset wb_addr",  {59'd0, wb_addr},  64'd0);
    check("reset wb_data",  wb_data,           64'd0);
    check("reset stall",    {63'd0, stall},    64'd0);
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    cycle(); cycle();
    reset = 0;
    checking = 1;

    set_alu(5'd3, 1, 64'h1234); cycle(); idle_in();
    check("alu wb_en",   {63'd0, wb_en},    64'd1);
    check("alu wb_addr", {59'd0, wb_addr},  64'd3);
    check("alu wb_data", wb_data,           64'h1234);
    check("alu ready",   {63'd0, in_ready}, 64'd1);

    set_load(5'd5, 2'd0, 1, 3'd2, 1, 64'h0000_0000_0080_0000); cycle(); idle_in();
    check("ld1 wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    check("ld1 wb_en",   {63'd0, wb_en}, 64'd1);

    set_load(5'd7, 2'd1, 0, 3'd0, 0, 64'h0); cycle(); idle_in();
    for (int i = 0; i < 2; i++) begin
      check("wait stall", {63'd0, stall}, 64'd1);
      cycle();
    end
    check("wait stall3", {63'd0, stall},    64'd1);
    check("wait ready",  {63'd0, in_ready}, 64'd0);
    mem_rvalid = 1; mem_rdata = 64'hDEAD_0000_0000_BEEF; cycle(); idle_in();
    check("ldN wb_data", wb_data, 64'hBEEF);
    check("ldN wb_addr", {59'd0, wb_addr}, 64'd7);
    check("ldN stall",   {63'd0, stall}, 64'd0);

    set_alu(5'd31, 1, 64'hABCD); cycle(); idle_in();
    check("xzr wb_en",   {63'd0, wb_en}, 64'd0);
    check("xzr wb_data", wb_data, 64'hABCD);

    set_load(5'd6, 2'd2, 1, 3'd4, 1, 64'h8765_4321_0000_0000); cycle(); idle_in();
    check("word sext", wb_data, 64'hFFFF_FFFF_8765_4321);
    set_load(5'd8, 2'd1, 1, 3'd7, 1, 64'hFF00_0000_0000_0000); cycle(); idle_in();
    check("half past top", wb_data, 64'h0000_0000_0000_00FF);
    set_load(5'd9, 2'd3, 1, 3'd0, 1, 64'h8000_0000_0000_0001); cycle(); idle_in();
    check("dword", wb_data, 64'h8000_0000_0000_0001);
    set_alu(5'd10, 0, 64'h55); cycle(); idle_in();
    check("no regwrite", {63'd0, wb_en}, 64'd0);
    mem_rvalid = 1; mem_rdata = 64'h77; cycle(); idle_in();
    check("stray idle en",   {63'd0, wb_en}, 64'd0);
    check("stray idle data", wb_data, 64'h55);

    set_load(5'd31, 2'd0, 0, 3'd0, 0, 64'h0); cycle(); idle_in();
    cycle();
    mem_rvalid = 1; mem_rdata = 64'h42; cycle(); idle_in();
    check("xzr load en",   {63'd0, wb_en}, 64'd0);
    check("xzr load data", wb_data, 64'h42);

    set_load(5'd12, 2'd0, 0, 3'd0, 0, 64'h0); cycle(); idle_in();
    #2 reset = 1;
    #1;
    check("rst mid stall", {63'd0, stall}, 64'd0);
    check("rst mid en",    {63'd0, wb_en}, 64'd0);
    check("rst mid data",  wb_data, 64'd0);
    cycle();
    reset = 0;
    mem_rvalid = 1; mem_rdata = 64'h99; cycle(); idle_in();
    check("stray after rst", {63'd0, wb_en}, 64'd0);

    set_alu(5'd1, 1, 64'h11); cycle();
    set_load(5'd2, 2'd2, 0, 3'd0, 0, 64'h0); cycle(); idle_in();
    cycle(); cycle();
    mem_rvalid = 1; mem_rdata = 64'h2222; cycle(); idle_in();
    check("perf seq data", wb_data, 64'h2222);
`ifdef WB_PERF_CNT_EN
    check("retire_cnt", {32'd0, retire_cnt}, 64'd2);
    check("stall_cnt",  {32'd0, stall_cnt},  64'd3);
`endif
    cycle();
    checking = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/write_back_pipe.md
Name: write_back_pipe

Overview:
- Parametrised, registered write-back stage for the pipelined CPU.
- Accepts MEM/WB entries under a valid/ready handshake.
- Selects ALU result or load data; for loads, extracts and zero/sign-extends the sub-word.
- Waits on a variable-latency data memory, then drives one register-file write port plus a stall to upstream stages.

Parameters:
WIDTH, 64, datapath width in bits; must be a multiple of 8, minimum 32
ADDR_W, 5, register address width
ZERO_REG, 31, register index whose writes are suppressed (XZR)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  MEM/WB entry valid
in_ready  out  1  stage can accept an entry this cycle
in_memtoreg  in  1  1 = write load data, 0 = write ALU result
in_regwrite  in  1  entry writes the register file
in_rd  in  ADDR_W  destination register
in_alu_result  in  WIDTH  ALU result
in_size  in  2  load size: 0 byte, 1 half, 2 word, 3 dword
in_signed  in  1  sign-extend the load
in_byte_off  in  OFF_W  byte offset within the memory word; OFF_W = $clog2(WIDTH/8)
mem_rvalid  in  1  load data valid
mem_rdata  in  WIDTH  load data
wb_en  out  1  register write enable
wb_addr  out  ADDR_W  register write address
wb_data  out  WIDTH  register write data
stall  out  1  upstream must hold (load outstanding)

Behaviour:
- Reset (async, asserting immediately):
  - state = IDLE.
  - wb_en = 0, wb_addr = 0, wb_data = 0, stall = 0.
  - Pending-load registers cleared.
- Outputs wb_en, wb_addr and wb_data are registered.
- in_ready = (state == IDLE); stall = (state == WAIT_MEM); both are combinational from state.
- Accept = in_valid & in_ready.
- State IDLE:
  - Accept with memtoreg = 0: next cycle wb_en = regwrite & (rd != ZERO_REG), wb_addr = rd, wb_data = alu_result. Stay IDLE. Latency 1.
  - Accept with memtoreg = 1 and mem_rvalid in the same cycle: next cycle write the extended mem_rdata. Stay IDLE. Latency 1.
  - Accept with memtoreg = 1 and no mem_rvalid: capture rd, regwrite, size, signed and byte_off, then go to WAIT_MEM. wb_en = 0 next cycle.
  - No accept: wb_en = 0 next cycle. wb_addr and wb_data hold.
  - mem_rvalid with no load being accepted is ignored.
- State WAIT_MEM:
  - in_ready = 0; upstream holds its inputs.
  - On mem_rvalid: next cycle write the extended data using the captured fields, and return to IDLE. The next entry can be accepted in that same cycle.
  - Without mem_rvalid: stay in WAIT_MEM. There is no timeout.
- Load extraction:
  - shifted = mem_rdata >> (byte_off*8).
  - Keep the low 8, 16, 32 or 64 bits for size 0, 1, 2 or 3.
  - Any size >= WIDTH/8 bytes passes full width unchanged, e.g. size 3 when WIDTH = 32.
  - in_signed = 1: replicate the top kept bit. Otherwise zero-fill.
  - A byte_off that pushes the field past the top of the word returns the available bits, zero-filled above.
- ZERO_REG suppression:
  - Writes to ZERO_REG never assert wb_en.
  - wb_addr and wb_data still update.
  - A load to ZERO_REG still waits for mem_rvalid.
- Reset in WAIT_MEM discards the pending load. A later mem_rvalid from that load is ignored in IDLE.

Optional Feature:
Macro WB_PERF_CNT_EN.
- Defined, two extra 32-bit outputs are added:
  - retire_cnt: increments on each cycle the wb_en register is updated to 1.
  - stall_cnt: increments on each cycle with stall = 1.
- Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- ALU path: accept rd = 3, regwrite = 1, memtoreg = 0, alu = 0x1234 -> next cycle wb_en = 1, wb_addr = 3, wb_data = 0x1234; in_ready stays 1.
- Single-cycle load: rd = 5, size = 0, signed = 1, byte_off = 2, mem_rvalid with rdata = 0x0000_0000_0080_0000 in the same cycle -> next cycle wb_data = 0xFFFF_FFFF_FFFF_FF80.
- Multi-cycle load: accept the load with no rvalid -> stall = 1 and in_ready = 0 for 3 cycles. rvalid arrives with rdata = 0xBEEF, size = 1, signed = 0 -> next cycle wb_data = 0xBEEF and stall = 0.
- XZR: ALU write to rd = 31 -> wb_en stays 0 and wb_data = the ALU value.
- Reset in WAIT_MEM: assert reset mid-wait -> wb_en = 0 and stall = 0 immediately. A later stray mem_rvalid produces no write.
- With WB_PERF_CNT_EN defined: 2 retired writes and a 3-cycle stall -> retire_cnt = 2, stall_cnt = 3.
